// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG byte collector and its health-test block.
package trng_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    FAILED  = 1'b1
  } trng_state_e;

  localparam int BYTE_W       = 8;
  localparam int DROP_CNT_MAX = 255;
  // Wide enough for any cutoff in 2..255.
  localparam int RUN_W        = 8;

endpackage

// File: rtl/trng_rct.sv
// Repetition-count health test: tracks the run of identical raw bits and flags
// the bit that makes the run reach the cutoff.
module trng_rct
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_fail,
  input  logic bit_in,
  input  logic bit_valid,
  output logic rct_trip
);

  logic [RUN_W-1:0] run_len_reg;
  logic [RUN_W-1:0] run_len_next;
  logic             last_bit_reg;

  // A zero run length marks the first bit after reset or clear.
  always_comb begin
    run_len_next = run_len_reg;
    if (bit_valid) begin
      if ((run_len_reg == '0) || (bit_in != last_bit_reg)) begin
        run_len_next = RUN_W'(1);
      end else if (run_len_reg != '1) begin
        run_len_next = run_len_reg + RUN_W'(1);
      end
    end
  end

  assign rct_trip = bit_valid && (run_len_next == RUN_W'(RCT_CUTOFF));

  always_ff @(posedge clk) begin
    if (rst || clr_fail) begin
      run_len_reg  <= '0;
      last_bit_reg <= 1'b0;
    end else if (bit_valid) begin
      run_len_reg  <= run_len_next;
      last_bit_reg <= bit_in;
    end
  end

endmodule

// File: rtl/trng_byte_collector.sv
// Health-tested entropy bit to byte assembler with a FWFT byte FIFO.
// Optional von Neumann debiaser enabled by defining TRNG_VN_DEBIAS_EN.
module trng_byte_collector
  import trng_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bit_in,
  input  logic                        bit_valid,
  input  logic                        rd_ready,
  output logic [BYTE_W-1:0]           rd_data,
  output logic                        rd_valid,
  input  logic                        clr_fail,
  output logic                        fail,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  drop_cnt
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          CW       = $clog2(BYTE_W);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  trng_state_e state_reg;
  trng_state_e state_next;

  logic collecting;
  logic clr_go;
  logic raw_valid;
  logic rct_trip;
  logic accept;
  logic asm_valid;
  logic asm_bit;

  assign collecting = (state_reg == COLLECT);
  assign clr_go     = (state_reg == FAILED) && clr_fail;
  assign raw_valid  = collecting && bit_valid;
  assign accept     = raw_valid && !rct_trip;

  trng_rct #(
    .RCT_CUTOFF (RCT_CUTOFF)
  ) u_rct (
    .clk       (clk),
    .rst       (rst),
    .clr_fail  (clr_go),
    .bit_in    (bit_in),
    .bit_valid (raw_valid),
    .rct_trip  (rct_trip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  // A trip can only occur in COLLECT and a clear only acts in FAILED.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (rct_trip) state_next = FAILED;
      FAILED:  if (clr_fail) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  assign fail = (state_reg == FAILED);

`ifdef TRNG_VN_DEBIAS_EN
  logic pair_half_reg;
  logic pair_first_reg;

  always_ff @(posedge clk) begin
    if (rst || clr_go || rct_trip) begin
      pair_half_reg  <= 1'b0;
      pair_first_reg <= 1'b0;
    end else if (accept) begin
      pair_half_reg <= !pair_half_reg;
      if (!pair_half_reg) pair_first_reg <= bit_in;
    end
  end

  // Pair 10 emits 1, 01 emits 0: the emitted bit equals the first of the pair.
  assign asm_valid = accept && pair_half_reg && (pair_first_reg != bit_in);
  assign asm_bit   = pair_first_reg;
`else
  assign asm_valid = accept;
  assign asm_bit   = bit_in;
`endif

  logic [BYTE_W-2:0] shift_reg;
  logic [CW-1:0]     bit_cnt_reg;
  logic              byte_done;
  logic [BYTE_W-1:0] new_byte;

  assign byte_done = asm_valid && (bit_cnt_reg == CW'(BYTE_W-1));
  assign new_byte  = {shift_reg, asm_bit};

  always_ff @(posedge clk) begin
    if (rst || clr_go || rct_trip) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (asm_valid) begin
      shift_reg   <= new_byte[BYTE_W-2:0];
      bit_cnt_reg <= bit_cnt_reg + CW'(1);
    end
  end

  logic [BYTE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic [7:0]        drop_cnt_reg;
  logic              pop;
  logic              push_ok;
  logic              drop;

  assign rd_valid = collecting && (count_reg != '0);
  assign pop      = rd_valid && rd_ready;
  // When full, a same-cycle pop frees the slot the write pointer lands on.
  assign push_ok  = byte_done && ((count_reg != FULL_LVL) || pop);
  assign drop     = byte_done && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= new_byte;
  end

  always_ff @(posedge clk) begin
    if (rst || rct_trip) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != 8'(DROP_CNT_MAX))) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign rd_data    = rd_valid ? mem[rd_ptr_reg] : '0;
  assign fifo_level = count_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_trng_byte_collector.sv
// Randomized and directed bench for trng_byte_collector against a queue-based model.
// Define TRNG_VN_DEBIAS_EN to exercise the debiased build.
module tb_trng_byte_collector;

  localparam int DEPTH  = 4;
  localparam int CUTOFF = 32;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in;
  logic          bit_valid;
  logic          rd_ready;
  logic          clr_fail;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          fail;
  logic [LW-1:0] fifo_level;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  trng_byte_collector #(
    .FIFO_DEPTH (DEPTH),
    .RCT_CUTOFF (CUTOFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .clr_fail   (clr_fail),
    .fail       (fail),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes as a queue, the partial byte as a bit list.
  logic [7:0] m_fifo[$];
  logic       m_bits[$];
  bit         m_failed;
  int         m_run;
  logic       m_last;
  int         m_drop;
  bit         m_pair_have;
  logic       m_pair_first;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_fifo.delete();
    m_bits.delete();
    m_failed     = 1'b0;
    m_run        = 0;
    m_last       = 1'b0;
    m_drop       = 0;
    m_pair_have  = 1'b0;
    m_pair_first = 1'b0;
  endfunction

  function automatic void model_emit(input logic b);
    logic [7:0] byt;
    m_bits.push_back(b);
    if (m_bits.size() == 8) begin
      byt = '0;
      for (int i = 0; i < 8; i++) byt = {byt[6:0], m_bits[i]};
      m_bits.delete();
      if (m_fifo.size() < DEPTH) m_fifo.push_back(byt);
      else if (m_drop < 255) m_drop++;
    end
  endfunction

  function automatic void model_step(input logic b, input logic v, input logic rdy, input logic clr);
    if (m_failed) begin
      if (clr) begin
        m_failed    = 1'b0;
        m_run       = 0;
        m_last      = 1'b0;
        m_bits.delete();
        m_pair_have = 1'b0;
      end
    end else begin
      if (rdy && (m_fifo.size() > 0)) void'(m_fifo.pop_front());
      if (v) begin
        if ((m_run == 0) || (b != m_last)) m_run = 1;
        else m_run++;
        m_last = b;
        if (m_run == CUTOFF) begin
          m_failed    = 1'b1;
          m_fifo.delete();
          m_bits.delete();
          m_pair_have = 1'b0;
        end else begin
`ifdef TRNG_VN_DEBIAS_EN
          if (!m_pair_have) begin
            m_pair_have  = 1'b1;
            m_pair_first = b;
          end else begin
            m_pair_have = 1'b0;
            if (m_pair_first != b) model_emit(m_pair_first);
          end
`else
          model_emit(b);
`endif
        end
      end
    end
  endfunction

  task automatic check_outputs();
    logic       exp_v;
    logic [7:0] exp_d;
    exp_v = !m_failed && (m_fifo.size() > 0);
    exp_d = exp_v ? m_fifo[0] : 8'h00;
    check("rd_valid", 32'(rd_valid), 32'(exp_v));
    check("rd_data", 32'(rd_data), 32'(exp_d));
    check("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
    check("fail", 32'(fail), 32'(m_failed));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input logic b, input logic v, input logic rdy, input logic clr);
    check_outputs();
    bit_in    = b;
    bit_valid = v;
    rd_ready  = rdy;
    clr_fail  = clr;
    model_step(b, v, rdy, clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    rd_ready  = 1'b0;
    clr_fail  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_bit(input logic b, input logic rdy);
`ifdef TRNG_VN_DEBIAS_EN
    cycle(b, 1'b1, rdy, 1'b0);
    cycle(!b, 1'b1, rdy, 1'b0);
`else
    cycle(b, 1'b1, rdy, 1'b0);
`endif
  endtask

  task automatic send_byte(input logic [7:0] byt, input logic rdy);
    for (int i = 7; i >= 0; i--) send_bit(byt[i], rdy);
  endtask

  task automatic read_expect(input string tag, input logic [7:0] exp);
    check(tag, 32'(rd_data), 32'(exp));
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int p;
    logic [19:0] seq;
    rst       = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    rd_ready  = 1'b0;
    clr_fail  = 1'b0;
    @(negedge clk);
    do_reset();

    check("reset_fail", 32'(fail), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_level", 32'(fifo_level), 32'd0);
    check("reset_drop", 32'(drop_cnt), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);

    // Single byte with a ready reader: visible for exactly one cycle.
    send_byte(8'hA5, 1'b1);
    check("single_valid", 32'(rd_valid), 32'd1);
    check("single_data", 32'(rd_data), 32'hA5);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("single_gone", 32'(rd_valid), 32'd0);

    // Overflow: fifth byte dropped, first four read back in order.
    do_reset();
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b0);
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_drop", 32'(drop_cnt), 32'd1);
    for (int k = 1; k <= 4; k++) read_expect("ovf_read", 8'(k));
    check("ovf_empty", 32'(fifo_level), 32'd0);

    // Health failure, ignored bits, then clear and a fresh byte.
    do_reset();
    repeat (CUTOFF) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("hf_fail", 32'(fail), 32'd1);
    check("hf_level", 32'(fifo_level), 32'd0);
    check("hf_rd_valid", 32'(rd_valid), 32'd0);
    repeat (12) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
    check("hf_sticky", 32'(fail), 32'd1);
    check("hf_ignored", 32'(fifo_level), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("hf_cleared", 32'(fail), 32'd0);
    send_byte(8'h3C, 1'b0);
    check("hf_after_fail", 32'(fail), 32'd0);
    check("hf_after_data", 32'(rd_data), 32'h3C);

`ifndef TRNG_VN_DEBIAS_EN
    // One short of the cutoff never trips.
    do_reset();
    repeat (CUTOFF - 1) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("sub_fail", 32'(fail), 32'd0);
    check("sub_level", 32'(fifo_level), 32'd4);
    read_expect("sub_read0", 8'hFF);
    read_expect("sub_read1", 8'hFF);
    read_expect("sub_read2", 8'hFF);
    read_expect("sub_read3", 8'hFE);
`endif

    // Reset in the middle of a byte loses the partial bits.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    send_byte(8'hC3, 1'b0);
    check("midrst_level", 32'(fifo_level), 32'd1);
    check("midrst_data", 32'(rd_data), 32'hC3);

`ifdef TRNG_VN_DEBIAS_EN
    // Pairs 10,01,11,10,00,01,10,10,01,10 emit 1,0,1,0,1,1,0,1 = 8'hAD.
    do_reset();
    seq = 20'b10_01_11_10_00_01_10_10_01_10;
    for (int i = 19; i >= 0; i--) cycle(seq[i], 1'b1, 1'b0, 1'b0);
    check("vn_level", 32'(fifo_level), 32'd1);
    check("vn_data", 32'(rd_data), 32'hAD);
`endif

    // Random traffic with varying bias so runs reach the cutoff at times.
    do_reset();
    p = 50;
    for (int n = 0; n < 4000; n++) begin
      if ((n % 200) == 0) begin
        case ($urandom_range(0, 2))
          0:       p = 50;
          1:       p = 95;
          default: p = 5;
        endcase
      end
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 99) < p),
              ($urandom_range(0, 99) < 85),
              ($urandom_range(0, 99) < 50),
              ($urandom_range(0, 99) < 4));
      end
    end

    // Drop counter saturation with a stalled reader.
    do_reset();
    for (int n = 0; (n < 40000) && (m_drop < 255); n++) begin
      cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    end
    check("drop_sat", 32'(drop_cnt), 32'd255);
    repeat (200) cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    check("drop_hold", 32'(drop_cnt), 32'd255);

    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
